// File: rtl/aether_mem_pkg.sv
// Shared types for the Aether memory task interface: engine command encoding,
// initiator FSM states and inclusive-range length arithmetic.
package aether_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_READ  = 2'd2
  } mem_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_FLUSH
  } init_state_e;

  // 33-bit so that 0..0xFFFFFFFF yields 2^32 instead of wrapping to 0.
  function automatic logic [32:0] range_len(input logic [31:0] first, input logic [31:0] last);
    return {1'b0, last} - {1'b0, first} + 33'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; a push into an empty FIFO is
// visible on data_o one cycle later.
module sync_fifo #(
  parameter int Width = 16,
  parameter int Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q;
  logic [Width-1:0] head_q, head_d;
  logic             pop_eff, push_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(Depth));
  assign pop_eff  = pop_i && !empty_o;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_eff = push_i && (!full_o || pop_eff);
  assign rd_ptr_d = pop_eff ? rd_ptr_q + AW'(1) : rd_ptr_q;
  // Bypass when the next head is the word being written this cycle.
  assign head_d   = (push_eff && (rd_ptr_d == wr_ptr_q)) ? data_i : mem_q[rd_ptr_d];
  assign data_o   = head_q;
  assign count_o  = count_q;

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_q + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/aether_mem_initiator.sv
// Requesting side of the Aether memory task interface: admits block-transfer
// requests, issues one-cycle engine commands and moves data through two FIFOs.
module aether_mem_initiator
  import aether_mem_pkg::*;
#(
  parameter int          FifoDepth     = 16,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_start_i,
  input  logic [31:0] req_end_i,
  input  logic [15:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic [15:0] rd_data_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  mem_command_o,
  output logic [31:0] mem_start_o,
  output logic [31:0] mem_end_o,
  output logic        mem_en_o,
  output logic [15:0] mem_data_write_o,
  input  logic        mem_write_ready_i,
  input  logic        mem_read_valid_i,
  input  logic [15:0] mem_data_read_i,
  input  logic        mem_task_finished_i,
  input  logic        mem_running_i
);

  localparam int CW = $clog2(FifoDepth) + 1;

  init_state_e state_q;
  mem_cmd_e    cmd_q;
  logic        dir_write_q, done_q, err_q;
  logic [31:0] start_q, end_q, cnt_q;
  logic [32:0] cnt_d, req_len, rd_free;
  logic        accept, reject, timeout_hit;
  logic        wr_push, wr_pop, wr_full, wr_empty;
  logic        rd_push, rd_pop, rd_full, rd_empty;
  logic [CW-1:0] wr_count, rd_count;

  assign req_ready_o = !rst_i && (state_q == ST_IDLE) && !mem_running_i;
  assign accept      = req_valid_i && req_ready_o;
  assign req_len     = range_len(req_start_i, req_end_i);
  assign rd_free     = 33'(FifoDepth) - 33'(rd_count);
  assign reject      = (req_end_i < req_start_i) || (!req_write_i && (req_len > rd_free));
  assign cnt_d       = {1'b0, cnt_q} + 33'd1;
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_d == 33'(TimeoutCycles));

  assign mem_command_o = rst_i ? MEM_IDLE : cmd_q;
  assign mem_en_o      = !rst_i && (state_q == ST_RUN) && dir_write_q && !wr_empty;
  assign mem_start_o   = start_q;
  assign mem_end_o     = end_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

  assign wr_ready_o = !rst_i && !wr_full;
  assign wr_push    = wr_valid_i && wr_ready_o;
  assign wr_pop     = mem_en_o && mem_write_ready_i;
  // FLUSH still captures a valid word the engine presents alongside finish.
  assign rd_push    = !dir_write_q && ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && mem_read_valid_i;
  assign rd_valid_o = !rd_empty;
  assign rd_pop     = rd_ready_i && rd_valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= MEM_IDLE;
      dir_write_q <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_q  <= MEM_IDLE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              dir_write_q <= req_write_i;
              start_q     <= req_start_i;
              end_q       <= req_end_i;
              cmd_q       <= req_write_i ? MEM_WRITE : MEM_READ;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
        ST_RUN: begin
          if (mem_task_finished_i) begin
            state_q <= ST_FLUSH;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d[31:0];
          end
        end
        ST_FLUSH: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(.Width(16), .Depth(FifoDepth)) u_wr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_push),
    .data_i  (wr_data_i),
    .pop_i   (wr_pop),
    .data_o  (mem_data_write_o),
    .full_o  (wr_full),
    .empty_o (wr_empty),
    .count_o (wr_count)
  );

  sync_fifo #(.Width(16), .Depth(FifoDepth)) u_rd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rd_push),
    .data_i  (mem_data_read_i),
    .pop_i   (rd_pop),
    .data_o  (rd_data_o),
    .full_o  (rd_full),
    .empty_o (rd_empty),
    .count_o (rd_count)
  );

  // Admission reserves room for every read word, so overflow means an engine fault.
  a_rd_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rd_push && rd_full && !rd_pop));
  a_wr_count_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
    wr_empty == (wr_count == '0));

endmodule

// File: doc/aether_mem_initiator.md
# aether_mem_initiator

Requesting side of the Aether engine memory task interface. Accepts block-transfer requests (write N words / read N words over an inclusive address range) from the compute pipeline and issues them as single-cycle commands to the generic memory engine. Streams write data out of a local write FIFO under the engine's ready/enable handshake and captures read data into a local read FIFO. Sits between the layer sequencer and the memory engine, one per memory port.

## Interface
- FifoDepth, 16: words per FIFO (power of two, ≥2); maximum read task length.
- TimeoutCycles, 65535: RUN-state cycles without task completion before abort (0 disables).
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid && ready
- req_write_i  in  1  1 = write task, 0 = read task
- req_start_i  in  32  first address
- req_end_i  in  32  last address (inclusive)
- wr_data_i / wr_valid_i / wr_ready_o  in 16 / in 1 / out 1  write-data stream into write FIFO
- rd_data_o / rd_valid_o / rd_ready_i  out 16 / out 1 / in 1  read-data stream out of read FIFO
- done_o  out  1  one-cycle pulse, task completed
- err_o  out  1  one-cycle pulse, request rejected or task timed out
- mem_command_o  out  2  0 idle, 1 write, 2 read
- mem_start_o / mem_end_o  out  32  task range, held stable from ISSUE until the initiator returns to IDLE
- mem_en_o  out  1  engine advance enable (write tasks)
- mem_data_write_o  out  16  write FIFO head
- mem_write_ready_i / mem_read_valid_i / mem_data_read_i / mem_task_finished_i / mem_running_i  in  1/1/16/1/1  engine status

## Operation
- FSM states: IDLE, ISSUE, RUN, FLUSH.
- IDLE: req_ready_o = 1 iff !mem_running_i. On accept:
  - reject (err_o pulse, stay IDLE) if req_end_i < req_start_i, or if read and (end−start+1) > read-FIFO free slots;
  - otherwise latch range and direction, go ISSUE.
- Length arithmetic is 33-bit, to avoid wrap at 0xFFFFFFFF.
- ISSUE: mem_command_o = direction for exactly one cycle, then RUN.
- RUN write:
  - mem_en_o = write FIFO non-empty;
  - pop when mem_en_o && mem_write_ready_i;
  - empty FIFO stalls the engine without error.
- RUN read: push mem_data_read_i on each mem_read_valid_i. Push into a full FIFO is impossible by the admission check; assert it.
- RUN → FLUSH on mem_task_finished_i. FLUSH lasts one cycle (absorbs the engine's trailing valid), pulses done_o, then IDLE.
- Timeout: a 32-bit cycle counter clears on entering RUN. When it reaches TimeoutCycles: err_o pulse, mem_en_o low, go IDLE. FIFO contents are kept.
- Write words beyond the task length stay in the write FIFO for the next task.
- The read FIFO drains independently of FSM state.

## Timing
- Reset values: req_ready_o 0 during reset, 1 the cycle after. All other outputs 0. Both FIFOs empty, state IDLE, counters 0.
- Reset mid-task: mem_command_o and mem_en_o drop in the reset cycle. Data is discarded, with no done_o and no err_o.
- Accept at cycle N → mem_command_o nonzero at N+1 only → RUN from N+2.
- done_o pulses the cycle after the first mem_task_finished_i seen in RUN. The earliest next accept is the cycle after done_o.
- FIFOs use registered outputs:
  - write-FIFO push → visible on mem_data_write_o after 1 cycle;
  - read-FIFO push → rd_valid_o after 1 cycle.
- Simultaneous push and pop on a full or empty FIFO: pop takes effect, and push succeeds only if a slot frees in the same cycle (full + pop + push allowed; empty + push + pop is not a pop).
- wr_ready_o = write FIFO not full, independent of FSM state.

## Structure
- Package aether_mem_pkg holds the command encoding (typedef enum logic [1:0] {MEM_IDLE, MEM_WRITE, MEM_READ}) and the initiator state enum. The memory engine imports the same package.
- Sub-module sync_fifo (Width, Depth; push/pop/full/empty/count), instantiated twice.
- FSM, admission check and timeout counter live in the top module.

## Test plan
- Write task 0x10–0x13 with 4 words preloaded and engine ready each cycle → command = 1 for one cycle, 4 pops in order, done_o one cycle after finish.
- Read task 0x10–0x13 with engine returning A,B,C,D → rd_data_o streams A..D; holding rd_ready_i low produces no loss.
- Read of 17 words with FifoDepth 16 → err_o pulse, mem_command_o stays 0, FSM stays IDLE. Also req_end_i < req_start_i → err_o.
- Write task with FIFO empty for 5 cycles → mem_en_o low for those cycles, then resumes; no error.
- TimeoutCycles = 8 with the engine never finishing → err_o at RUN entry + 8, mem_en_o 0, next request accepted.
- rst_i asserted mid-write → all outputs 0 the next cycle, FIFOs empty, req_ready_o 1 the cycle after reset is released.
